// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register target: FSM states, ACK polarity, R/W bit position.
package i2c_pkg;

  typedef enum logic [3:0] {
    s_idle,
    s_addr,
    s_addr_ack,
    s_reg,
    s_reg_ack,
    s_wdata,
    s_wdata_ack,
    s_rdata,
    s_rdata_ack,
    s_ignore
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_h, sda_h, scl_s;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_h    <= scl_sync[SYNC_STAGES-1];
      sda_h    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_h;
  assign scl_fall  = ~scl_s &  scl_h;
  assign start_det =  scl_s &  scl_h &  sda_h & ~sda_s;
  assign stop_det  =  scl_s &  scl_h & ~sda_h &  sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register target: 1-byte register pointer with auto-increment, external register port.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR   = 7'h39,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] tx;
  logic [7:0] rx_byte;
  logic       sda_oe, rw, rd_lat;
  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign busy    = (state != s_idle);
  assign rx_byte = {sr, sda_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= s_idle;
      bit_cnt  <= '0;
      sr       <= '0;
      tx       <= '0;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      rd_lat   <= 1'b0;
      reg_addr <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_req <= 1'b0;
      rd_lat <= rd_req;
      // Pointer bumps the clk after each write strobe or read-data latch.
      if (wr_en) reg_addr <= reg_addr + 8'd1;
      if (rd_lat) begin
        tx       <= rd_data;
        reg_addr <= reg_addr + 8'd1;
      end
      if (start_det) begin
        state   <= s_addr;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= s_idle;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          s_addr, s_reg, s_wdata: begin
            if (scl_rise) begin
              sr      <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == s_addr) begin
                  if (rx_byte[7:1] == CHIP_ADDR) begin
                    state  <= s_addr_ack;
                    rw     <= rx_byte[RW_BIT];
                    rd_req <= rx_byte[RW_BIT];
                  end else begin
                    state <= s_ignore;
                  end
                end else if (state == s_reg) begin
                  reg_addr <= rx_byte;
                  state    <= s_reg_ack;
                end else begin
                  wr_data <= rx_byte;
                  wr_en   <= 1'b1;
                  state   <= s_wdata_ack;
                end
              end
            end
          end
          // bit_cnt==0: first fall starts the ACK; bit_cnt==1: second fall ends it.
          s_addr_ack, s_reg_ack, s_wdata_ack: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                bit_cnt <= '0;
                if (state == s_addr_ack && rw) begin
                  state  <= s_rdata;
                  sda_oe <= ~tx[7];
                end else begin
                  state  <= (state == s_addr_ack) ? s_reg : s_wdata;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          s_rdata: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= s_rdata_ack;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          s_rdata_ack: begin
            if (scl_rise) begin
              if (sda_s == ACK) begin
                rd_req  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                state <= s_ignore;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              state   <= s_rdata;
              sda_oe  <= ~tx[7];
            end
          end
          s_idle, s_ignore: ;
          default: state <= s_idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C master against the register target, with write/read monitors.
module tb_i2c_reg_slave;

  localparam int Q = 200;

  logic       clk = 1'b0, reset = 1'b0, scl = 1'b1, m_oe = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_req, busy;

  int errors = 0, checks = 0;
  int wr_cnt = 0, rd_cnt = 0, dut_low = 0, both = 0;
  logic [7:0] wr_a [16], wr_d [16], rd_a [16];

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  assign rd_data = (reg_addr == 8'h98) ? 8'h03 : (reg_addr == 8'h99) ? 8'hE0 : 8'h5A;

  i2c_reg_slave #(.CHIP_ADDR(7'h39), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a[wr_cnt[3:0]] <= reg_addr;
      wr_d[wr_cnt[3:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_req) begin
      rd_a[rd_cnt[3:0]] <= reg_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (!m_oe && sda === 1'b0) dut_low <= dut_low + 1;
    if (wr_en && rd_req) both <= both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic r);
    m_oe = ~b; #Q;
    scl = 1'b1; #Q;
    r = (sda === 1'b0) ? 1'b0 : 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, r);
      d = {d[6:0], r};
    end
    send_bit(mack, r);
  endtask

  task automatic start_c();
    m_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    m_oe = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_oe = 1'b0; #Q; #Q;
  endtask

  initial begin
    logic a0, a1, a2, a3, r;
    logic [7:0] d1, d2;
    int low0;

    #100;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'h00);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_sda", 32'(sda === 1'b1), 32'd1);
    reset = 1'b1; #Q;

    // single write 0x41 <= 0x00
    start_c(); send_byte(8'h72, a0); send_byte(8'h41, a1); send_byte(8'h00, a2); stop_c();
    check("w1_acks", 32'({a0, a1, a2}), 32'd0);
    check("w1_cnt", 32'(wr_cnt), 32'd1);
    check("w1_addr", 32'(wr_a[0]), 32'h41);
    check("w1_data", 32'(wr_d[0]), 32'h00);
    check("w1_busy", 32'(busy), 32'd0);

    // burst write across the 0xFF wrap
    start_c(); send_byte(8'h72, a0); send_byte(8'hFE, a1);
    send_byte(8'hAA, a2); send_byte(8'hBB, a3); send_byte(8'hCC, r); stop_c();
    check("w2_acks", 32'({a0, a1, a2, a3, r}), 32'd0);
    check("w2_cnt", 32'(wr_cnt), 32'd4);
    check("w2_addr0", 32'(wr_a[1]), 32'hFE);
    check("w2_addr1", 32'(wr_a[2]), 32'hFF);
    check("w2_addr2", 32'(wr_a[3]), 32'h00);
    check("w2_data0", 32'(wr_d[1]), 32'hAA);
    check("w2_data2", 32'(wr_d[3]), 32'hCC);
    check("w2_reg_addr", 32'(reg_addr), 32'h01);

    // wrong chip address
    low0 = dut_low;
    start_c(); send_byte(8'h74, a0); send_byte(8'h41, a1); send_byte(8'h55, a2); stop_c();
    check("wa_nack", 32'({a0, a1, a2}), 32'h7);
    check("wa_sda_low", 32'(dut_low - low0), 32'd0);
    check("wa_cnt", 32'(wr_cnt), 32'd4);
    check("wa_reg_addr", 32'(reg_addr), 32'h01);
    check("wa_busy", 32'(busy), 32'd0);

    // pointer set, repeated START, two-byte read
    start_c(); send_byte(8'h72, a0); send_byte(8'h98, a1);
    start_c(); send_byte(8'h73, a2);
    recv_byte(1'b0, d1); recv_byte(1'b1, d2);
    check("rd_acks", 32'({a0, a1, a2}), 32'd0);
    check("rd_sda_rel", 32'(sda === 1'b1), 32'd1);
    stop_c();
    check("rd_byte0", 32'(d1), 32'h03);
    check("rd_byte1", 32'(d2), 32'hE0);
    check("rd_cnt", 32'(rd_cnt), 32'd2);
    check("rd_addr0", 32'(rd_a[0]), 32'h98);
    check("rd_addr1", 32'(rd_a[1]), 32'h99);
    check("rd_reg_addr", 32'(reg_addr), 32'h9A);
    check("rd_no_wr", 32'(wr_cnt), 32'd4);

    // reset after 4 address bits
    start_c(); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b1, r); send_bit(1'b1, r);
    m_oe = 1'b0; reset = 1'b0; #50;
    check("mr_sda", 32'(sda === 1'b1), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    scl = 1'b1; #Q; reset = 1'b1; #Q;
    start_c(); send_byte(8'h72, a0); send_byte(8'h16, a1); send_byte(8'h30, a2); stop_c();
    check("mr_acks", 32'({a0, a1, a2}), 32'd0);
    check("mr_cnt", 32'(wr_cnt), 32'd5);
    check("mr_addr", 32'(wr_a[4]), 32'h16);
    check("mr_data", 32'(wr_d[4]), 32'h30);

    // STOP after 5 data bits
    start_c(); send_byte(8'h72, a0); send_byte(8'h50, a1);
    send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r);
    stop_c();
    check("ps_acks", 32'({a0, a1}), 32'd0);
    check("ps_cnt", 32'(wr_cnt), 32'd5);
    check("ps_busy", 32'(busy), 32'd0);
    check("ps_sda", 32'(sda === 1'b1), 32'd1);
    check("ps_reg_addr", 32'(reg_addr), 32'h50);

    check("no_rd_wr_overlap", 32'(both), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target (responder) with an external 8-bit register-port interface.
- Single-byte register address and single-byte data per access; register pointer auto-increments across bursts.
- Other end of the team's I2C master register-write path. Used as an on-chip debug/config target and as a bus-functional responder for master-side init sequences on the FPGA.
- Open-drain SDA only. SCL is never driven (no clock stretching).

Parameters:
- CHIP_ADDR, 7'h39, 7-bit target address. Bus write byte is 0x72, read byte is 0x73.
- SYNC_STAGES, 2, synchronizer depth on SDA and SCL (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; driven 0 or 'z' only.
- reg_addr  output  8  current register pointer.
- wr_data  output  8  received data byte; valid while wr_en is high.
- wr_en  output  1  one-clk write strobe.
- rd_req  output  1  one-clk read request for reg_addr.
- rd_data  input  8  must be valid exactly 1 clk after rd_req.
- busy  output  1  high whenever state != s_idle.

Behaviour:
- Reset values: sda='z', reg_addr=0, wr_data=0, wr_en=0, rd_req=0, busy=0, state=s_idle, bit_cnt=0.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).
- Synchronization and edge detection:
  - SDA and SCL each pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected on the synchronized values.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled on SCL rising edges, MSB first.
  - SDA drive changes only on SCL falling edges.
- START, including repeated START, from any state:
  - Go to s_addr with bit_cnt=0 and SDA released.
  - reg_addr is retained.
- STOP from any state: go to s_idle and release SDA.
- States: s_idle, s_addr, s_addr_ack, s_reg, s_reg_ack, s_wdata, s_wdata_ack, s_rdata, s_rdata_ack, s_ignore.
- s_addr, after 8 bits:
  - If byte[7:1] != CHIP_ADDR, go to s_ignore, which is left only on START/STOP.
  - Otherwise go to s_addr_ack. SDA=0 from the next SCL fall until the following SCL fall.
- After the address ACK:
  - R/W=0 goes to s_reg.
  - R/W=1 goes to s_rdata.
- s_reg: the 8 received bits load reg_addr, then ACK and go to s_wdata.
- s_wdata:
  - On the SCL rise sampling bit 8, wr_data is loaded and wr_en pulses 1 clk with the current reg_addr.
  - reg_addr increments 1 clk later, wrapping 0xFF to 0x00.
  - Then ACK and return to s_wdata.
- Read path:
  - rd_req pulses 1 clk after the address byte matches with R/W=1.
  - rd_data is latched into the shift register the next clk.
  - The first bit is driven at the SCL fall that ends the ACK slot.
  - Each 0 bit drives SDA=0; each 1 bit releases SDA.
  - reg_addr increments after each latch.
- s_rdata_ack (SDA released), master's ACK bit sampled on SCL rise:
  - ACK (0): issue rd_req and go to s_rdata.
  - NACK (1): go to s_ignore.
- Simultaneous events: START/STOP detection overrides any data-bit action in the same clk. wr_en is not issued for a partial byte.
- rd_req and wr_en never assert in the same clk.

Decomposition:
- Package i2c_pkg holds:
  - state encodings;
  - the ACK=1'b0 / NACK=1'b1 constants;
  - the R/W bit position.
- Sub-module i2c_line_sync: synchronizers plus outputs scl_rise, scl_fall, start_det, stop_det and sda_s. The main FSM consumes only these outputs.

Test Plan:
- Single write: START, 0x72, 0x41, 0x00, STOP.
  - ACK on all 3 bytes.
  - Exactly one wr_en with reg_addr=0x41, wr_data=0x00.
  - busy returns to 0 after STOP.
- Burst write with wrap: 0x72, 0xFE, then data 0xAA, 0xBB, 0xCC.
  - wr_en x3 at addresses 0xFE, 0xFF, 0x00.
  - Final reg_addr=0x01.
- Wrong address: 0x74, 0x41, 0x55.
  - SDA never driven low by the DUT.
  - No wr_en; reg_addr unchanged.
  - busy returns to 0 after STOP.
- Read with repeated START: 0x72, 0x98, Sr, 0x73; bench returns rd_data=0x03 then 0xE0; master ACKs byte 1 and NACKs byte 2.
  - Bus bytes observed: 0x03, 0xE0.
  - rd_req at reg_addr 0x98 and 0x99.
  - SDA released after the NACK.
- Reset mid-byte: assert reset after 4 bits of the 0x72 byte.
  - sda='z' and busy=0 within the reset.
  - A following full write of 0x16=0x30 completes normally.
- STOP inside s_wdata after 5 data bits: no wr_en, state=s_idle, SDA released.
